// File: rtl/ghost_move_ctrl.sv
// Ghost move controller: reads the four neighbours of one ghost from the distance map
// and steps toward pacman. Optional macro GHOST_TUNNEL_WRAP_EN makes x wrap at the map edges.
module ghost_move_ctrl #(
    parameter int MAP_W      = 40,
    parameter int MAP_H      = 30,
    parameter int RD_LATENCY = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       ready,
    input  logic       start,
    input  logic [5:0] ghost_x,
    input  logic [4:0] ghost_y,
    output logic [5:0] rdaddr_x,
    output logic [4:0] rdaddr_y,
    input  logic [7:0] data,
    output logic       busy,
    output logic       move_valid,
    output logic [5:0] next_x,
    output logic [4:0] next_y,
    output logic [1:0] dir,
    output logic       stuck,
    output logic [2:0] fsm_state
);

    // Handshake: start is sampled only in IDLE with ready high; move_valid is a
    // one-cycle pulse and next_x/next_y/dir/stuck hold until the next pulse.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DECIDE  = 3'd4
    } state_t;

    typedef struct packed {
        logic       ok;
        logic [5:0] x;
        logic [4:0] y;
    } nbr_t;

    localparam int         WAIT_CYC  = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 0;
    localparam logic [7:0] WAIT_LAST = (WAIT_CYC > 0) ? 8'(WAIT_CYC - 1) : 8'd0;
    localparam logic [5:0] X_MAX     = 6'(MAP_W - 1);
    localparam logic [4:0] Y_MAX     = 5'(MAP_H - 1);

    state_t     state;
    logic [1:0] k;
    logic [7:0] wait_cnt;
    logic [5:0] gx;
    logic [4:0] gy;
    logic       cur_ok;
    logic [7:0] cand [4];

    // Neighbour kk of (x,y) in order up, left, down, right; ok=0 when off-map.
    function automatic nbr_t nbr(input logic [1:0] kk, input logic [5:0] x, input logic [4:0] y);
        nbr_t n;
        n.ok = 1'b1;
        n.x  = x;
        n.y  = y;
        case (kk)
            2'd0: if (y == 5'd0) n.ok = 1'b0; else n.y = y - 5'd1;
            2'd1: begin
                if (x == 6'd0) begin
`ifdef GHOST_TUNNEL_WRAP_EN
                    n.x = X_MAX;
`else
                    n.ok = 1'b0;
`endif
                end else begin
                    n.x = x - 6'd1;
                end
            end
            2'd2: if (y == Y_MAX) n.ok = 1'b0; else n.y = y + 5'd1;
            default: begin
                if (x == X_MAX) begin
`ifdef GHOST_TUNNEL_WRAP_EN
                    n.x = 6'd0;
`else
                    n.ok = 1'b0;
`endif
                end else begin
                    n.x = x + 6'd1;
                end
            end
        endcase
        return n;
    endfunction

    nbr_t       cur_nb;
    nbr_t       sel_nb;
    logic [1:0] best_k;
    logic [1:0] rev_k;
    logic [1:0] sel_k;
    logic [7:0] best_v;
    logic       have_min;
    logic       have_rev;
    logic       sel_stuck;

    assign cur_nb = nbr(k, gx, gy);

    // Strict less-than keeps the lowest k on ties; 253 (reversal) only as a fallback.
    always_comb begin
        best_k   = 2'd0;
        best_v   = 8'hFF;
        have_min = 1'b0;
        rev_k    = 2'd0;
        have_rev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cand[i] < 8'd253) begin
                if (!have_min || cand[i] < best_v) begin
                    have_min = 1'b1;
                    best_v   = cand[i];
                    best_k   = 2'(i);
                end
            end else if (cand[i] == 8'd253 && !have_rev) begin
                have_rev = 1'b1;
                rev_k    = 2'(i);
            end
        end
    end

    assign sel_k     = have_min ? best_k : rev_k;
    assign sel_stuck = !have_min && !have_rev;
    assign sel_nb    = nbr(sel_k, gx, gy);
    assign fsm_state = state;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            k          <= 2'd0;
            wait_cnt   <= 8'd0;
            gx         <= 6'd0;
            gy         <= 5'd0;
            cur_ok     <= 1'b0;
            rdaddr_x   <= 6'd0;
            rdaddr_y   <= 5'd0;
            busy       <= 1'b0;
            move_valid <= 1'b0;
            next_x     <= 6'd0;
            next_y     <= 5'd0;
            dir        <= 2'd0;
            stuck      <= 1'b0;
            for (int i = 0; i < 4; i++) cand[i] <= 8'd0;
        end else begin
            move_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && ready) begin
                        gx    <= ghost_x;
                        gy    <= ghost_y;
                        k     <= 2'd0;
                        busy  <= 1'b1;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Off-map neighbours leave the read port untouched.
                    if (cur_nb.ok) begin
                        rdaddr_x <= cur_nb.x;
                        rdaddr_y <= cur_nb.y;
                    end
                    cur_ok   <= cur_nb.ok;
                    wait_cnt <= 8'd0;
                    state    <= (WAIT_CYC == 0) ? S_CAPTURE : S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= S_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_CAPTURE: begin
                    cand[k] <= cur_ok ? data : 8'hFF;
                    if (k == 2'd3) begin
                        state <= S_DECIDE;
                    end else begin
                        k     <= k + 2'd1;
                        state <= S_ISSUE;
                    end
                end
                S_DECIDE: begin
                    if (sel_stuck) begin
                        next_x <= gx;
                        next_y <= gy;
                        dir    <= 2'd0;
                        stuck  <= 1'b1;
                    end else begin
                        next_x <= sel_nb.x;
                        next_y <= sel_nb.y;
                        dir    <= sel_k;
                        stuck  <= 1'b0;
                    end
                    move_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ghost_move_ctrl.sv
// Directed bench for ghost_move_ctrl: a latency-2 map RAM model, a driver issuing move
// requests, and a monitor popping expected moves whenever move_valid is seen.
module tb_ghost_move_ctrl;

    localparam int MAP_W = 40;
    localparam int MAP_H = 30;
    localparam int LAT   = 13;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       ready    = 1'b0;
    logic       start    = 1'b0;
    logic [5:0] ghost_x  = 6'd0;
    logic [4:0] ghost_y  = 5'd0;
    logic [5:0] rdaddr_x;
    logic [4:0] rdaddr_y;
    logic [7:0] data     = 8'd0;
    logic       busy;
    logic       move_valid;
    logic [5:0] next_x;
    logic [4:0] next_y;
    logic [1:0] dir;
    logic       stuck;
    logic [2:0] fsm_state;

    ghost_move_ctrl #(.MAP_W(MAP_W), .MAP_H(MAP_H), .RD_LATENCY(2)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .ready(ready), .start(start),
        .ghost_x(ghost_x), .ghost_y(ghost_y), .rdaddr_x(rdaddr_x), .rdaddr_y(rdaddr_y),
        .data(data), .busy(busy), .move_valid(move_valid), .next_x(next_x),
        .next_y(next_y), .dir(dir), .stuck(stuck), .fsm_state(fsm_state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int total     = 0;
    int bad       = 0;
    int cyc       = 0;
    int mv_count  = 0;
    int mv_expect = 0;
    int oob_reads = 0;

    logic [13:0] exp_q[$];
    int          exp_t_q[$];
    logic [7:0]  mem [MAP_H][MAP_W];

    always @(posedge CLOCK_50) cyc++;

    // Map RAM model: address is registered at one edge, data captured by the DUT at the next.
    always @(posedge CLOCK_50) begin
        if (rdaddr_x < 6'(MAP_W) && rdaddr_y < 5'(MAP_H))
            data <= mem[rdaddr_y][rdaddr_x];
        else
            data <= 8'hEE;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every move_valid pulse must match the oldest outstanding request.
    always @(negedge CLOCK_50) begin
        if (rdaddr_x >= 6'(MAP_W) || rdaddr_y >= 5'(MAP_H)) oob_reads++;
        if (move_valid === 1'b1) begin
            mv_count++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_move_valid actual=%0h expected=none",
                         {next_x, next_y, dir, stuck});
            end else begin
                check("move_result", 32'({next_x, next_y, dir, stuck}), 32'(exp_q.pop_front()));
                if (exp_t_q.size() != 0)
                    check("move_latency", 32'(cyc), 32'(exp_t_q.pop_front()));
            end
        end
    end

    task automatic set_nbrs(input int gx, input int gy, input logic [7:0] u, input logic [7:0] l,
                            input logic [7:0] d, input logic [7:0] r);
        if (gy > 0)         mem[gy-1][gx] = u;
        if (gx > 0)         mem[gy][gx-1] = l;
        if (gy < MAP_H - 1) mem[gy+1][gx] = d;
        if (gx < MAP_W - 1) mem[gy][gx+1] = r;
    endtask

    task automatic run_move(input int gx, input int gy, input int ex, input int ey, input int ed,
                            input bit es, input bit restart, input bit drop_ready);
        logic [13:0] e;
        int          c;
        e = {6'(ex), 5'(ey), 2'(ed), es};
        exp_q.push_back(e);
        mv_expect++;
        @(negedge CLOCK_50);
        ghost_x = 6'(gx);
        ghost_y = 5'(gy);
        start   = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        exp_t_q.push_back(cyc + LAT);
        check("busy_after_accept", 32'(busy), 32'd1);
        ghost_x = 6'($urandom_range(0, MAP_W - 1));
        ghost_y = 5'($urandom_range(0, MAP_H - 1));
        if (drop_ready) ready = 1'b0;
        if (restart) begin
            repeat (4) @(negedge CLOCK_50);
            start = 1'b1;
            @(negedge CLOCK_50);
            start = 1'b0;
        end
        c = 0;
        while (exp_q.size() != 0 && c < 40) begin
            @(negedge CLOCK_50);
            #1;
            c++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL move_timeout actual=no_move_valid expected=move within %0d clocks", LAT);
            exp_q.delete();
            exp_t_q.delete();
        end
        ready = 1'b1;
        @(negedge CLOCK_50);
        #1;
        check("outputs_held", 32'({next_x, next_y, dir, stuck}), 32'(e));
        check("pulse_one_cycle", 32'({move_valid, busy}), 32'd0);
    endtask

    initial begin
        for (int y = 0; y < MAP_H; y++)
            for (int x = 0; x < MAP_W; x++)
                mem[y][x] = 8'd200;

        #1;
        check("reset_outputs", 32'({busy, move_valid, stuck, dir, rdaddr_x, rdaddr_y, next_x, next_y}), 32'd0);
        check("reset_state", 32'(fsm_state), 32'd0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b1;
        ready = 1'b1;

        // Minimum with tie on left/down: left wins.
        set_nbrs(10, 5, 8'd7, 8'd5, 8'd5, 8'd9);
        run_move(10, 5, 9, 5, 1, 1'b0, 1'b0, 1'b0);
        // Only a reversal is available.
        set_nbrs(10, 5, 8'd255, 8'd254, 8'd253, 8'd255);
        run_move(10, 5, 10, 6, 2, 1'b0, 1'b0, 1'b0);
        // Fully walled in.
        set_nbrs(10, 5, 8'd255, 8'd255, 8'd255, 8'd255);
        run_move(10, 5, 10, 5, 0, 1'b1, 1'b0, 1'b0);
        // Top-left corner; (39,0) only reachable through the tunnel.
        mem[1][0]  = 8'd3;
        mem[0][1]  = 8'd3;
        mem[0][39] = 8'd1;
`ifdef GHOST_TUNNEL_WRAP_EN
        run_move(0, 0, 39, 0, 1, 1'b0, 1'b0, 1'b0);
`else
        run_move(0, 0, 0, 1, 2, 1'b0, 1'b0, 1'b0);
`endif
        // Bottom-right corner; (0,29) only reachable through the tunnel.
        mem[28][39] = 8'd4;
        mem[29][38] = 8'd6;
        mem[29][0]  = 8'd2;
`ifdef GHOST_TUNNEL_WRAP_EN
        run_move(39, 29, 0, 29, 3, 1'b0, 1'b0, 1'b0);
`else
        run_move(39, 29, 39, 28, 0, 1'b0, 1'b0, 1'b0);
`endif
        // Distance 0 is a legal move; three-way tie goes to left.
        set_nbrs(20, 10, 8'd10, 8'd0, 8'd0, 8'd0);
        run_move(20, 10, 19, 10, 1, 1'b0, 1'b0, 1'b0);
        // 252 is a distance and beats the 253 reversal.
        set_nbrs(20, 10, 8'd253, 8'd255, 8'd254, 8'd252);
        run_move(20, 10, 21, 10, 3, 1'b0, 1'b0, 1'b0);
        // ready dropping mid-sequence does not abort it.
        set_nbrs(5, 20, 8'd30, 8'd31, 8'd29, 8'd29);
        run_move(5, 20, 5, 21, 2, 1'b0, 1'b0, 1'b1);
        // A second start while busy is dropped.
        set_nbrs(10, 5, 8'd7, 8'd5, 8'd5, 8'd9);
        run_move(10, 5, 9, 5, 1, 1'b0, 1'b1, 1'b0);

        // start with ready low is ignored.
        ready = 1'b0;
        @(negedge CLOCK_50);
        ghost_x = 6'd3;
        ghost_y = 5'd3;
        start   = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        start = 1'b0;
        #1;
        check("no_busy_when_not_ready", 32'(busy), 32'd0);
        repeat (20) @(negedge CLOCK_50);
        ready = 1'b1;

        // Reset in the sixth clock of a request aborts it.
        set_nbrs(10, 5, 8'd7, 8'd5, 8'd5, 8'd9);
        @(negedge CLOCK_50);
        ghost_x = 6'd10;
        ghost_y = 5'd5;
        start   = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        check("busy_before_abort", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_outputs", 32'({busy, move_valid, stuck, dir, rdaddr_x, rdaddr_y, next_x, next_y}), 32'd0);
        check("abort_state", 32'(fsm_state), 32'd0);
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        #1;
        check("no_move_after_abort", 32'(move_valid), 32'd0);
        set_nbrs(10, 5, 8'd2, 8'd5, 8'd5, 8'd9);
        run_move(10, 5, 10, 4, 0, 1'b0, 1'b0, 1'b0);

        repeat (20) @(negedge CLOCK_50);
        check("move_valid_count", 32'(mv_count), 32'(mv_expect));
        check("offmap_reads", 32'(oob_reads), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
